// File: rtl/tone_sequencer.sv
// Note-table sequencer feeding freq_hertz/tone_enable to the square-wave divider.
// Define TONE_SEQ_GAP_EN to insert GAP_MS ms of silence between consecutive notes.
module tone_sequencer #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DUR_WIDTH  = 16,
  parameter int unsigned GAP_MS     = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_freq,
  input  logic [DUR_WIDTH-1:0]     wr_dur,
  input  logic [$clog2(DEPTH):0]   length,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  output logic [WIDTH-1:0]         freq_hertz,
  output logic                     tone_enable,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] note_index,
  output logic                     done
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned LW         = AW + 1;
  localparam int unsigned TicksPerMs = CLOCK_FREQ / 1000;
  localparam int unsigned PW         = (TicksPerMs > 1) ? $clog2(TicksPerMs) : 1;

`ifdef TONE_SEQ_GAP_EN
  localparam int unsigned GapMs = (GAP_MS == 0) ? 1 : GAP_MS;
  localparam int unsigned GW    = $clog2(GapMs + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPlay,
    StGap,
    StDone
  } state_e;

  logic [GW-1:0] gap_cnt;
`else
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPlay,
    StDone
  } state_e;
`endif

  state_e state;

  logic [WIDTH-1:0]     freq_mem [DEPTH];
  logic [DUR_WIDTH-1:0] dur_mem  [DEPTH];

  logic [LW-1:0]        len_q;
  logic                 loop_q;
  logic [DUR_WIDTH-1:0] dur_cnt;
  logic [PW-1:0]        prescale;

  logic                 ms_tick;
  logic                 last_slot;
  logic                 seq_end;
  logic [AW-1:0]        next_index;
  logic [LW-1:0]        len_clamped;
  logic [WIDTH-1:0]     rd_freq;
  logic [DUR_WIDTH-1:0] rd_dur;
  logic [DUR_WIDTH-1:0] dur_load;

  // Note RAM: no reset, writable in every state.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      freq_mem[wr_addr] <= wr_freq;
      dur_mem[wr_addr]  <= wr_dur;
    end
  end

  always_comb begin
    ms_tick     = (prescale == PW'(TicksPerMs - 1));
    last_slot   = !({1'b0, note_index} < (len_q - LW'(1)));
    seq_end     = last_slot && !loop_q;
    next_index  = last_slot ? '0 : note_index + AW'(1);
    len_clamped = (length > LW'(DEPTH)) ? LW'(DEPTH) : length;
    rd_freq     = freq_mem[note_index];
    rd_dur      = dur_mem[note_index];
    dur_load    = (rd_dur == '0) ? DUR_WIDTH'(1) : rd_dur;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      freq_hertz  <= '0;
      tone_enable <= 1'b0;
      busy        <= 1'b0;
      note_index  <= '0;
      done        <= 1'b0;
      len_q       <= '0;
      loop_q      <= 1'b0;
      dur_cnt     <= '0;
      prescale    <= '0;
`ifdef TONE_SEQ_GAP_EN
      gap_cnt     <= '0;
`endif
    end else if (stop) begin
      state       <= StIdle;
      freq_hertz  <= '0;
      tone_enable <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done     <= 1'b0;
      prescale <= ms_tick ? '0 : prescale + PW'(1);
      unique case (state)
        StIdle: begin
          if (start && (length != '0)) begin
            len_q      <= len_clamped;
            loop_q     <= loop;
            note_index <= '0;
            busy       <= 1'b1;
            state      <= StLoad;
          end
        end
        // Registered read of the slot is the RAM's synchronous read port.
        StLoad: begin
          freq_hertz  <= rd_freq;
          tone_enable <= (rd_freq != '0);
          dur_cnt     <= dur_load;
          prescale    <= '0;
          state       <= StPlay;
        end
        StPlay: begin
          if (ms_tick) begin
            if (dur_cnt == DUR_WIDTH'(1)) begin
              if (seq_end) begin
                freq_hertz  <= '0;
                tone_enable <= 1'b0;
                done        <= 1'b1;
                state       <= StDone;
              end else begin
                note_index <= next_index;
`ifdef TONE_SEQ_GAP_EN
                freq_hertz  <= '0;
                tone_enable <= 1'b0;
                gap_cnt     <= GW'(GapMs);
                prescale    <= '0;
                state       <= StGap;
`else
                state       <= StLoad;
`endif
              end
            end else begin
              dur_cnt <= dur_cnt - DUR_WIDTH'(1);
            end
          end
        end
`ifdef TONE_SEQ_GAP_EN
        StGap: begin
          if (ms_tick) begin
            if (gap_cnt == GW'(1)) begin
              state <= StLoad;
            end else begin
              gap_cnt <= gap_cnt - GW'(1);
            end
          end
        end
`endif
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed self-checking bench for tone_sequencer at 10 cycles/ms, DEPTH=4.
// Build with TONE_SEQ_GAP_EN defined to exercise the inter-note gap instead.
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [31:0] wr_freq = '0;
  logic [15:0] wr_dur = '0;
  logic [2:0]  length = '0;
  logic        loop = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] freq_hertz;
  logic        tone_enable;
  logic        busy;
  logic [1:0]  note_index;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;
  int cnt;
  logic [31:0] exp_f [4];

  tone_sequencer #(
    .CLOCK_FREQ(10_000),
    .WIDTH     (32),
    .DEPTH     (4),
    .DUR_WIDTH (16),
    .GAP_MS    (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_freq    (wr_freq),
    .wr_dur     (wr_dur),
    .length     (length),
    .loop       (loop),
    .start      (start),
    .stop       (stop),
    .freq_hertz (freq_hertz),
    .tone_enable(tone_enable),
    .busy       (busy),
    .note_index (note_index),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] f, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_freq = f;
    wr_dur  = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Leaves the bench sampling in the LOAD cycle after an accepted start.
  task automatic start_seq(input logic [2:0] len, input logic lp);
    length = len;
    loop   = lp;
    start  = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_freq", freq_hertz, 0);
    chk("rst_te", tone_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", note_index, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    tick();

`ifdef TONE_SEQ_GAP_EN
    wr(2'd0, 32'd500, 16'd1);
    wr(2'd1, 32'd600, 16'd1);
    start_seq(3'd2, 1'b0);
    tick();
    chk("gap_n0_freq", freq_hertz, 500);
    repeat (10) tick();
    // Silence spans the GAP_MS gap (10 cycles) plus the LOAD cycle.
    cnt = 0;
    while (busy && !tone_enable && freq_hertz == 0 && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("gap_silence_cycles", cnt, 11);
    chk("gap_n1_freq", freq_hertz, 600);
    chk("gap_n1_idx", note_index, 1);
    repeat (10) tick();
    chk("gap_last_done", done, 1);
    tick();
    chk("gap_idle_busy", busy, 0);
`else
    // Basic two-note sequence.
    wr(2'd0, 32'd440, 16'd3);
    wr(2'd1, 32'd880, 16'd2);
    start_seq(3'd2, 1'b0);
    chk("basic_load_busy", busy, 1);
    chk("basic_load_te", tone_enable, 0);
    tick();
    chk("basic_te_on", tone_enable, 1);
    chk("basic_freq0", freq_hertz, 440);
    cnt = 0;
    while (freq_hertz == 440 && note_index == 0 && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("basic_note0_len", cnt, 30);
    chk("basic_load_hold_freq", freq_hertz, 440);
    chk("basic_load_idx", note_index, 1);
    tick();
    chk("basic_freq1", freq_hertz, 880);
    cnt = 0;
    while (freq_hertz == 880 && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("basic_note1_len", cnt, 20);
    chk("basic_done", done, 1);
    chk("basic_done_te", tone_enable, 0);
    chk("basic_done_busy", busy, 1);
    tick();
    chk("basic_done_clr", done, 0);
    chk("basic_idle_busy", busy, 0);

    // Rest note.
    wr(2'd0, 32'd0, 16'd2);
    start_seq(3'd1, 1'b0);
    tick();
    cnt = 0;
    while (busy && !done && !tone_enable && freq_hertz == 0 && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("rest_len", cnt, 20);
    chk("rest_done", done, 1);
    tick();

    // Loop, then stop in PLAY.
    wr(2'd0, 32'd100, 16'd1);
    wr(2'd1, 32'd200, 16'd1);
    start_seq(3'd2, 1'b1);
    tick();
    chk("loop_idx_a", note_index, 0);
    chk("loop_freq_a", freq_hertz, 100);
    repeat (10) tick();
    tick();
    chk("loop_idx_b", note_index, 1);
    chk("loop_freq_b", freq_hertz, 200);
    repeat (10) tick();
    tick();
    chk("loop_idx_c", note_index, 0);
    chk("loop_freq_c", freq_hertz, 100);
    repeat (10) tick();
    tick();
    chk("loop_idx_d", note_index, 1);
    chk("loop_freq_d", freq_hertz, 200);
    repeat (3) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_te", tone_enable, 0);
    chk("stop_freq", freq_hertz, 0);
    chk("stop_busy", busy, 0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) cnt++;
      tick();
    end
    chk("stop_no_done", cnt, 0);

    // length=0 is ignored.
    start_seq(3'd0, 1'b0);
    chk("len0_busy", busy, 0);
    tick();
    chk("len0_busy_later", busy, 0);

    // length=7 clamps to 4 slots.
    exp_f[0] = 32'd11;
    exp_f[1] = 32'd22;
    exp_f[2] = 32'd33;
    exp_f[3] = 32'd44;
    for (int k = 0; k < 4; k++) wr(2'(k), exp_f[k], 16'd1);
    start_seq(3'd7, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("clamp_freq%0d", k), freq_hertz, exp_f[k]);
      repeat (10) tick();
    end
    chk("clamp_done", done, 1);
    tick();
    chk("clamp_idle", busy, 0);

    // dur=0 plays one millisecond.
    wr(2'd0, 32'd55, 16'd0);
    start_seq(3'd1, 1'b0);
    tick();
    cnt = 0;
    while (freq_hertz == 55 && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("dur0_len", cnt, 10);
    chk("dur0_done", done, 1);
    tick();

    // start and stop together: stop wins.
    length = 3'd1;
    start  = 1'b1;
    stop   = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_busy", busy, 0);
    tick();
    chk("startstop_busy_later", busy, 0);
    chk("startstop_te", tone_enable, 0);

    // Rewrite the playing slot, then reset mid-PLAY.
    wr(2'd0, 32'd300, 16'd2);
    wr(2'd1, 32'd400, 16'd1);
    start_seq(3'd2, 1'b1);
    tick();
    chk("rw_freq_initial", freq_hertz, 300);
    wr(2'd0, 32'd999, 16'd1);
    cnt = 0;
    while (freq_hertz == 300 && note_index == 0 && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("rw_current_kept", cnt, 19);
    tick();
    chk("rw_next_freq", freq_hertz, 400);
    repeat (10) tick();
    tick();
    chk("rw_new_freq", freq_hertz, 999);
    repeat (10) tick();
    tick();
    chk("rw_idx1", note_index, 1);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_freq", freq_hertz, 0);
    chk("mrst_te", tone_enable, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_idx", note_index, 0);
    chk("mrst_done", done, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
